// File: rtl/decoder_pipe_pkg.sv
// Shared types, defaults and the decode function for decoder_pipe_param.
//   decode_mode_e : runtime output encoding selected by in_mode.
//   skid_state_e  : occupancy of the 2-entry output buffer.
//   decode_vec()  : combinational decode of a select into {err, vec}.
package decoder_pipe_pkg;

  localparam int unsigned DEF_SEL_W   = 3;
  localparam int unsigned DEF_NUM_OUT = 8;
  localparam int unsigned DEF_CNT_W   = 16;

  // Upper bounds for the width-generic decode function; callers zero-extend
  // the select and truncate the returned vector to their own widths.
  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT   = 256;

  typedef enum logic [1:0] {
    DEC_ONEHOT,
    DEC_THERM,
    DEC_ONECOLD,
    DEC_RSVD
  } decode_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } skid_state_e;

  // Returns {err, vec}: err sits at bit MAX_OUT, vec occupies the LSBs, so a
  // plain truncating cast to NUM_OUT bits yields the output vector.
  // Bits at or above num_out are always 0.
  function automatic logic [MAX_OUT:0] decode_vec(
    input logic [MAX_SEL_W-1:0] sel,
    input logic                 en,
    input decode_mode_e         mode,
    input int unsigned          num_out,
    input int unsigned          sel_w
  );
    logic [MAX_OUT-1:0] vec;
    logic               err;
    logic               active;
    logic               in_range;
    logic [MAX_SEL_W:0] s_ext;
    logic [31:0]        s_cmp;

    // One spare bit above the select keeps the thermometer compare from
    // wrapping when sel is all ones.
    s_ext = {1'b0, sel};
    s_cmp = 32'(s_ext);

    // A fully populated output range cannot be exceeded, so skip the check.
    in_range = (num_out >= (32'd1 << sel_w)) || (s_cmp < num_out);
    err      = (mode == DEC_RSVD) || (en && !in_range);
    active   = en && in_range && (mode != DEC_RSVD);

    vec = '0;
    for (int unsigned i = 0; i < MAX_OUT; i++) begin
      if (i < num_out) begin
        case (mode)
          DEC_ONEHOT:  vec[i] = active && (i == s_cmp);
          DEC_THERM:   vec[i] = active && (i <= s_cmp);
          DEC_ONECOLD: vec[i] = !(active && (i == s_cmp));
          default:     vec[i] = 1'b0;
        endcase
      end
    end

    return {err, vec};
  endfunction

endpackage

// File: rtl/decoder_pipe_param_if.sv
// Request/result bus between producer and consumer of decoder_pipe_param.
//   in_valid/in_ready   : request handshake; in_sel/in_en/in_mode payload.
//   out_valid/out_ready : result handshake; out_vec/out_err payload.
//   master : producer+consumer side (drives requests, accepts results).
//   slave  : decoder side.
interface decoder_pipe_param_if
  import decoder_pipe_pkg::*;
#(
  parameter int unsigned SEL_W   = DEF_SEL_W,
  parameter int unsigned NUM_OUT = DEF_NUM_OUT
);

  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic               in_en;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_vec;
  logic               out_err;

  modport master (
    output in_valid, in_sel, in_en, in_mode, out_ready,
    input  in_ready, out_valid, out_vec, out_err
  );

  modport slave (
    input  in_valid, in_sel, in_en, in_mode, out_ready,
    output in_ready, out_valid, out_vec, out_err
  );

endinterface

// File: rtl/decoder_skid_buf.sv
// Two-entry valid/ready buffer: an output register plus one skid entry.
// in_ready is registered and equals "skid entry empty", so upstream sees
// backpressure one cycle after the buffer fills. Order is preserved.
//   clk, rst_n           : clock, synchronous active-low reset.
//   in_valid/in_ready    : upstream handshake, in_data payload.
//   out_valid/out_ready  : downstream handshake, out_data payload.
module decoder_skid_buf
  import decoder_pipe_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_data <= in_data;
          end else if (accept) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= ST_TWO;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (drain) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/decoder_pipe_param.sv
// Pipelined, parametrised N-to-NUM_OUT decoder with valid/ready flow control.
// The select is decoded before storage; the 2-entry skid buffer carries
// {out_err, out_vec}. dec_count counts accepted requests and saturates.
//   clk, rst_n : clock, synchronous active-low reset.
//   bus        : request/result bus (slave side).
//   dec_count  : accepted-request count, saturating at all ones.
module decoder_pipe_param
  import decoder_pipe_pkg::*;
#(
  parameter int unsigned SEL_W   = DEF_SEL_W,
  parameter int unsigned NUM_OUT = DEF_NUM_OUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_pipe_param_if.slave  bus,
  output logic [CNT_W-1:0]     dec_count
);

  logic [MAX_SEL_W-1:0] sel_ext;
  logic [NUM_OUT-1:0]   dec_vec;
  logic                 dec_err;
  logic [NUM_OUT:0]     buf_out;

  assign sel_ext = MAX_SEL_W'(bus.in_sel);

  // decode_vec returns a MAX_OUT+1 wide {err, vec}; the casts pick out only
  // the bits this instance uses.
  always_comb begin
    dec_vec = NUM_OUT'(decode_vec(sel_ext, bus.in_en, decode_mode_e'(bus.in_mode),
                                  NUM_OUT, SEL_W));
    dec_err = 1'(decode_vec(sel_ext, bus.in_en, decode_mode_e'(bus.in_mode),
                            NUM_OUT, SEL_W) >> MAX_OUT);
  end

  decoder_skid_buf #(
    .W (NUM_OUT + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({dec_err, dec_vec}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (buf_out)
  );

  assign bus.out_vec = buf_out[NUM_OUT-1:0];
  assign bus.out_err = buf_out[NUM_OUT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_count <= '0;
    end else if (bus.in_valid && bus.in_ready && (dec_count != '1)) begin
      dec_count <= dec_count + CNT_W'(1);
    end
  end

endmodule
